// File: rtl/vga_pixel_fifo.sv
// rtl/vga_pixel_fifo.sv - first-word-fall-through pixel FIFO feeding a VGA adapter
module vga_pixel_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic [7:0]                 in_x,
  input  logic [6:0]                 in_y,
  input  logic [2:0]                 in_color,
  input  logic                       in_plot,
  input  logic                       out_ready,
  input  logic                       clr_drops,
  output logic [7:0]                 VGA_X,
  output logic [6:0]                 VGA_Y,
  output logic [2:0]                 VGA_COLOR,
  output logic                       plot,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [17:0]   head;
  logic          on_screen;
  logic          pop;
  logic          push;
  logic          drop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign plot  = !empty;

  // Off-screen pixels are neither stored nor counted as drops.
  assign on_screen = in_plot && (in_x <= 8'd159) && (in_y <= 7'd119);
  assign pop       = !empty && out_ready;
  assign push      = on_screen && (!full || pop);
  assign drop      = on_screen && full && !pop;

  assign head      = mem[rd_ptr];
  assign VGA_X     = empty ? 8'd0 : head[17:10];
  assign VGA_Y     = empty ? 7'd0 : head[9:3];
  assign VGA_COLOR = empty ? 3'd0 : head[2:0];

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_color};
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (clr_drops) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb/tb_vga_pixel_fifo.sv - randomized and directed checks of vga_pixel_fifo against a queue model
module tb_vga_pixel_fifo;

  logic       clk;
  logic       resetn;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_color;
  logic       in_plot;
  logic       out_ready;
  logic       clr_drops;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [15:0] drop_count;

  int tests;
  int fails;

  logic [17:0] q[$];
  int          drops;

  vga_pixel_fifo #(.DEPTH(16)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_color  (in_color),
    .in_plot   (in_plot),
    .out_ready (out_ready),
    .clr_drops (clr_drops),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [17:0] h;
    int n;
    n = q.size();
    h = (n > 0) ? q[0] : 18'd0;
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".plot"},  32'(plot),  32'(n != 0));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"},  32'(full),  32'(n == 16));
    chk({tag, ".x"},     32'(VGA_X), 32'(h[17:10]));
    chk({tag, ".y"},     32'(VGA_Y), 32'(h[9:3]));
    chk({tag, ".color"}, 32'(VGA_COLOR), 32'(h[2:0]));
    chk({tag, ".drops"}, 32'(drop_count), 32'(drops));
  endtask

  // One clock: apply inputs, advance the reference model by the FIFO rules, then compare.
  task automatic step(input string tag, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                      input logic p, input logic r, input logic cl, input bit do_chk);
    bit was_full, do_pop, valid, dropped;
    logic [17:0] dummy;
    in_x = x; in_y = y; in_color = c; in_plot = p; out_ready = r; clr_drops = cl;
    was_full = (q.size() == 16);
    do_pop   = (q.size() > 0) && r;
    valid    = p && (x <= 8'd159) && (y <= 7'd119);
    dropped  = 1'b0;
    @(posedge clk); #1;
    if (do_pop) dummy = q.pop_front();
    if (valid) begin
      if (!was_full || do_pop) q.push_back({x, y, c});
      else dropped = 1'b1;
    end
    if (cl) drops = 0;
    else if (dropped && drops < 65535) drops++;
    if (do_chk) check_state(tag);
  endtask

  task automatic idle(input string tag, input logic r, input int n);
    for (int i = 0; i < n; i++) step(tag, 8'd0, 7'd0, 3'd0, 1'b0, r, 1'b0, 1'b1);
  endtask

  task automatic push_rand(input string tag, input logic r, input bit do_chk);
    step(tag, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom_range(0, 7)),
         1'b1, r, 1'b0, do_chk);
  endtask

  initial begin
    tests = 0; fails = 0; drops = 0;
    resetn = 1'b0; in_x = '0; in_y = '0; in_color = '0;
    in_plot = 1'b0; out_ready = 1'b0; clr_drops = 1'b0;
    #2;
    check_state("reset");
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    // First edge after release accepts a push
    step("first", 8'd10, 7'd20, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("first.x_const", 32'(VGA_X), 32'd10);
    chk("first.y_const", 32'(VGA_Y), 32'd20);
    chk("first.c_const", 32'(VGA_COLOR), 32'd5);
    chk("first.cnt_const", 32'(count), 32'd1);
    // Push and pop at count=1 presents the new pixel
    step("pp1", 8'd33, 7'd44, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    idle("drain0", 1'b1, 2);

    // Overflow: 20 pushes into 16 entries
    for (int i = 0; i < 20; i++) push_rand("ovf", 1'b0, 1'b1);
    chk("ovf.full_const", 32'(full), 32'd1);
    chk("ovf.drops_const", 32'(drop_count), 32'd4);
    idle("drain16", 1'b1, 16);
    chk("drain16.empty_const", 32'(empty), 32'd1);
    idle("empty_ready", 1'b1, 2);

    // Full FIFO with continuous push and pop
    for (int i = 0; i < 16; i++) push_rand("fill", 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) push_rand("stream", 1'b1, 1'b1);
    chk("stream.drops_const", 32'(drop_count), 32'd4);
    idle("drain_s", 1'b1, 17);

    // Off-screen pixels are ignored; screen corners are accepted
    step("off_x", 8'd160, 7'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("off_y", 8'd0, 7'd120, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("corner", 8'd159, 7'd119, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("drain_c", 1'b1, 2);

    // Randomized traffic, including off-screen coordinates and clears
    for (int i = 0; i < 400; i++)
      step("rand", 8'($urandom_range(0, 200)), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 40) == 0), 1'b1);
    idle("drain_r", 1'b1, 17);

    // Reset mid-drain with 7 entries
    for (int i = 0; i < 10; i++) push_rand("pre_rst", 1'b0, 1'b1);
    idle("pre_rst_drain", 1'b1, 3);
    chk("pre_rst.cnt_const", 32'(count), 32'd7);
    #2 resetn = 1'b0;
    q.delete(); drops = 0;
    #1 check_state("async_rst");
    @(posedge clk); #1;
    check_state("held_rst");
    resetn = 1'b1;
    step("post_rst", 8'd77, 7'd66, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("post_rst_drain", 1'b1, 2);

    // Drop counter saturation
    for (int i = 0; i < 16; i++) push_rand("sat_fill", 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) push_rand("sat_bulk", 1'b0, 1'b0);
    check_state("sat_reach");
    chk("sat.const", 32'(drop_count), 32'd65535);
    push_rand("sat_more", 1'b0, 1'b1);
    push_rand("sat_more", 1'b0, 1'b1);
    chk("sat.hold_const", 32'(drop_count), 32'd65535);
    step("clr_drop", 8'd1, 7'd1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr.const", 32'(drop_count), 32'd0);
    idle("final_drain", 1'b1, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
